// File: rtl/vga_box_layer_renderer.sv
// vga_box_layer_renderer: pipelined, prioritised multi-box layer for a VGA pixel stream.
// Box attributes are written into shadow slots and copied to the active slots on
// frame_start, so a frame is always drawn from one consistent set of boxes.
module vga_box_layer_renderer #(
   parameter int         NUM_BOXES   = 4,
   parameter int         IDX_W       = 2,
   parameter int         BLINK_SHIFT = 5,
   parameter logic [3:0] BG_R        = 4'h0,
   parameter logic [3:0] BG_G        = 4'h0,
   parameter logic [3:0] BG_B        = 4'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [10:0]      pix_x_in,
   input  logic [9:0]       pix_y_in,
   input  logic             in_screen,
   input  logic             frame_start,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [10:0]      cfg_x,
   input  logic [10:0]      cfg_w,
   input  logic [9:0]       cfg_y,
   input  logic [9:0]       cfg_h,
   input  logic [3:0]       cfg_r,
   input  logic [3:0]       cfg_g,
   input  logic [3:0]       cfg_b,
   input  logic             cfg_en,
   input  logic             cfg_blink,
   output logic [3:0]       VGA_R,
   output logic [3:0]       VGA_G,
   output logic [3:0]       VGA_B,
   output logic             write_out,
   output logic [IDX_W-1:0] hit_idx_out
);

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] w;
      logic [9:0]  y;
      logic [9:0]  h;
      logic [3:0]  r;
      logic [3:0]  g;
      logic [3:0]  b;
      logic        en;
      logic        blink;
   } slot_t;

   localparam logic [11:0] BG_COL = {BG_R, BG_G, BG_B};

   // Half-open rectangle test; end coordinates are one bit wider so large
   // boxes near the right/bottom edge clip instead of wrapping to zero.
   function automatic logic slot_hit(input slot_t s, input logic [10:0] px,
                                     input logic [9:0] py);
      logic [11:0] x_end;
      logic [10:0] y_end;
      x_end = {1'b0, s.x} + {1'b0, s.w};
      y_end = {1'b0, s.y} + {1'b0, s.h};
      return (px >= s.x) && ({1'b0, px} < x_end) &&
             (py >= s.y) && ({1'b0, py} < y_end);
   endfunction

   slot_t                  cfg_slot;
   slot_t                  shd_q     [NUM_BOXES];
   slot_t                  shd_d     [NUM_BOXES];
   slot_t                  act_q     [NUM_BOXES];
   slot_t                  act_d     [NUM_BOXES];
   logic [BLINK_SHIFT:0]   frm_cnt_q;
   logic [BLINK_SHIFT:0]   frm_cnt_d;
   logic                   visible;

   logic                   vld_p1_q;
   logic                   vld_p1_d;
   logic [NUM_BOXES-1:0]   hit_p1_q;
   logic [NUM_BOXES-1:0]   hit_p1_d;
   logic [11:0]            col_p1_q  [NUM_BOXES];
   logic [11:0]            col_p1_d  [NUM_BOXES];

   logic                   win_hit;
   logic [IDX_W-1:0]       win_idx;
   logic [11:0]            win_col;
   logic                   write_p2_q;
   logic                   write_p2_d;
   logic [IDX_W-1:0]       idx_p2_q;
   logic [IDX_W-1:0]       idx_p2_d;
   logic [11:0]            col_p2_q;
   logic [11:0]            col_p2_d;

   assign cfg_slot = {cfg_x, cfg_w, cfg_y, cfg_h, cfg_r, cfg_g, cfg_b, cfg_en, cfg_blink};

   // Shadow writes, frame-start commit and frame counter; commit copies the
   // shadow as it stood before any same-cycle write.
   always_comb begin
      shd_d     = shd_q;
      act_d     = act_q;
      frm_cnt_d = frm_cnt_q;
      if (frame_start) begin
         act_d     = shd_q;
         frm_cnt_d = frm_cnt_q + {{BLINK_SHIFT{1'b0}}, 1'b1};
      end
      if (cfg_we) begin
         for (int i = 0; i < NUM_BOXES; i++) begin
            if (cfg_idx == IDX_W'(i)) shd_d[i] = cfg_slot;
         end
      end
   end

   // Slot register state; indices beyond NUM_BOXES match no slot above.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BOXES; i++) begin
            shd_q[i] <= '0;
            act_q[i] <= '0;
         end
         frm_cnt_q <= '0;
      end else begin
         shd_q     <= shd_d;
         act_q     <= act_d;
         frm_cnt_q <= frm_cnt_d;
      end
   end

   // ---- stage 0 -> 1: per-slot hit test against the active slots
   always_comb begin
      visible  = ~frm_cnt_q[BLINK_SHIFT];
      vld_p1_d = in_screen;
      for (int i = 0; i < NUM_BOXES; i++) begin
         hit_p1_d[i] = act_q[i].en && (visible || !act_q[i].blink) && in_screen &&
                       slot_hit(act_q[i], pix_x_in, pix_y_in);
         col_p1_d[i] = {act_q[i].r, act_q[i].g, act_q[i].b};
      end
   end

   // Stage 1 registers; colours travel with the hit vector so a commit
   // between stages cannot recolour a pixel already in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         hit_p1_q <= '0;
      end else begin
         vld_p1_q <= vld_p1_d;
         hit_p1_q <= hit_p1_d;
      end
      col_p1_q <= col_p1_d;
   end

   // ---- stage 1 -> 2: lowest-index hit wins
   always_comb begin
      win_hit = 1'b0;
      win_idx = '0;
      win_col = BG_COL;
      for (int i = NUM_BOXES - 1; i >= 0; i--) begin
         if (hit_p1_q[i]) begin
            win_hit = 1'b1;
            win_idx = IDX_W'(i);
            win_col = col_p1_q[i];
         end
      end
      write_p2_d = vld_p1_q && win_hit;
      idx_p2_d   = write_p2_d ? win_idx : '0;
      col_p2_d   = write_p2_d ? win_col : BG_COL;
   end

   // Stage 2 output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         write_p2_q <= 1'b0;
         idx_p2_q   <= '0;
         col_p2_q   <= BG_COL;
      end else begin
         write_p2_q <= write_p2_d;
         idx_p2_q   <= idx_p2_d;
         col_p2_q   <= col_p2_d;
      end
   end

   assign VGA_R       = col_p2_q[11:8];
   assign VGA_G       = col_p2_q[7:4];
   assign VGA_B       = col_p2_q[3:0];
   assign write_out   = write_p2_q;
   assign hit_idx_out = idx_p2_q;

endmodule

// File: tb/tb_vga_box_layer_renderer.sv
// Testbench for vga_box_layer_renderer: directed scenarios plus random traffic,
// compared against a frame-level behavioural model with a two-cycle output delay.
module tb_vga_box_layer_renderer;

   localparam int         N    = 3;
   localparam int         IW   = 2;
   localparam int         BS   = 1;
   localparam logic [3:0] BGR  = 4'h1;
   localparam logic [3:0] BGG  = 4'h2;
   localparam logic [3:0] BGB  = 4'h3;
   localparam logic [14:0] BG_EXP = {1'b0, 2'b00, BGR, BGG, BGB};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [10:0]   px = '0;
   logic [9:0]    py = '0;
   logic          ins = 1'b0;
   logic          fs = 1'b0;
   logic          we = 1'b0;
   logic [IW-1:0] widx = '0;
   logic [10:0]   wx = '0, ww = '0;
   logic [9:0]    wy = '0, wh = '0;
   logic [3:0]    wr = '0, wg = '0, wb = '0;
   logic          wen = 1'b0, wbl = 1'b0;
   logic [3:0]    vr, vg, vb;
   logic          wo;
   logic [IW-1:0] hio;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int x, w, y, h, r, g, b, en, bl;
   } mslot_t;

   mslot_t m_shd [N];
   mslot_t m_act [N];
   int     m_frm = 0;
   logic [14:0] expq [$];

   always #5 clk = ~clk;

   vga_box_layer_renderer #(
      .NUM_BOXES(N), .IDX_W(IW), .BLINK_SHIFT(BS),
      .BG_R(BGR), .BG_G(BGG), .BG_B(BGB)
   ) dut (
      .clk(clk), .rst(rst), .pix_x_in(px), .pix_y_in(py), .in_screen(ins),
      .frame_start(fs), .cfg_we(we), .cfg_idx(widx), .cfg_x(wx), .cfg_w(ww),
      .cfg_y(wy), .cfg_h(wh), .cfg_r(wr), .cfg_g(wg), .cfg_b(wb),
      .cfg_en(wen), .cfg_blink(wbl), .VGA_R(vr), .VGA_G(vg), .VGA_B(vb),
      .write_out(wo), .hit_idx_out(hio)
   );

   task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got wr=%b idx=%0d rgb=%h, want wr=%b idx=%0d rgb=%h",
                  tag, got[14], got[13:12], got[11:0], exp[14], exp[13:12], exp[11:0]);
      end
   endtask

   // Frame-level view: which enabled, currently shown box covers the pixel first.
   function automatic logic [14:0] model_pix(int x, int y, bit on);
      bit hidden;
      hidden = ((m_frm / (2 ** BS)) % 2) == 1;
      if (on) begin
         for (int i = 0; i < N; i++) begin
            if (m_act[i].en != 0 && !(m_act[i].bl != 0 && hidden) &&
                x >= m_act[i].x && x < m_act[i].x + m_act[i].w &&
                y >= m_act[i].y && y < m_act[i].y + m_act[i].h)
               return {1'b1, IW'(i), 4'(m_act[i].r), 4'(m_act[i].g), 4'(m_act[i].b)};
         end
      end
      return BG_EXP;
   endfunction

   task automatic model_update();
      mslot_t z;
      z = '{default: 0};
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_shd[i] = z;
            m_act[i] = z;
         end
         m_frm = 0;
      end else begin
         if (fs) begin
            for (int i = 0; i < N; i++) m_act[i] = m_shd[i];
            m_frm = (m_frm + 1) % (2 ** (BS + 1));
         end
         if (we && int'(widx) < N)
            m_shd[widx] = '{x: int'(wx), w: int'(ww), y: int'(wy), h: int'(wh),
                            r: int'(wr), g: int'(wg), b: int'(wb),
                            en: int'(wen), bl: int'(wbl)};
      end
   endtask

   task automatic step(input string tag);
      if (rst) begin
         expq.delete();
         expq.push_back(BG_EXP);
      end else begin
         expq.push_back(model_pix(int'(px), int'(py), ins));
      end
      @(posedge clk);
      model_update();
      #1;
      if (rst) check({tag, "_rst"}, {wo, hio, vr, vg, vb}, BG_EXP);
      else if (expq.size() >= 2) check(tag, {wo, hio, vr, vg, vb}, expq.pop_front());
   endtask

   task automatic cfg(input int idx, input int x, input int w, input int y, input int h,
                      input int r, input int g, input int b, input bit en, input bit bl,
                      input bit with_fs);
      we = 1'b1; widx = IW'(idx);
      wx = 11'(x); ww = 11'(w); wy = 10'(y); wh = 10'(h);
      wr = 4'(r); wg = 4'(g); wb = 4'(b); wen = en; wbl = bl;
      fs = with_fs;
      step("cfg");
      we = 1'b0; fs = 1'b0;
   endtask

   task automatic frame();
      fs = 1'b1;
      step("frame");
      fs = 1'b0;
   endtask

   task automatic scan(input string tag, input int x0, input int x1, input int y, input bit on);
      for (int x = x0; x <= x1; x++) begin
         px = 11'(x); py = 10'(y); ins = on;
         step(tag);
      end
      ins = 1'b0;
      step(tag);
      step(tag);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) step("reset");
      rst = 1'b0;

      scan("idle", 0, 7, 20, 1'b1);

      cfg(0, 10, 5, 20, 3, 15, 0, 0, 1'b1, 1'b0, 1'b0);
      frame();
      scan("single", 9, 15, 20, 1'b1);
      scan("single_y", 9, 15, 23, 1'b1);

      cfg(2, 12, 10, 20, 3, 0, 15, 0, 1'b1, 1'b0, 1'b0);
      frame();
      scan("overlap", 9, 23, 21, 1'b1);

      cfg(0, 10, 5, 20, 3, 0, 0, 15, 1'b1, 1'b0, 1'b0);
      scan("tear_nofs", 10, 14, 20, 1'b1);
      cfg(0, 10, 5, 20, 3, 0, 0, 15, 1'b1, 1'b0, 1'b1);
      scan("tear_samecyc", 10, 14, 20, 1'b1);
      frame();
      scan("tear_commit", 10, 14, 20, 1'b1);

      cfg(1, 30, 4, 20, 3, 0, 15, 15, 1'b1, 1'b1, 1'b0);
      for (int f = 0; f < 8; f++) begin
         frame();
         scan("blink", 30, 31, 20, 1'b1);
         scan("noblink", 12, 12, 20, 1'b1);
      end

      cfg(1, 40, 0, 20, 3, 15, 15, 15, 1'b1, 1'b0, 1'b0);
      cfg(2, 2040, 20, 20, 3, 0, 15, 0, 1'b1, 1'b0, 1'b0);
      cfg(3, 100, 5, 20, 3, 15, 15, 0, 1'b1, 1'b0, 1'b0);
      frame();
      scan("w0", 39, 41, 20, 1'b1);
      scan("rightedge", 2038, 2047, 20, 1'b1);
      scan("nowrap", 0, 3, 20, 1'b1);
      scan("idx_oob", 99, 101, 20, 1'b1);
      scan("offscreen", 10, 14, 20, 1'b0);

      px = 11'd12; py = 10'd20; ins = 1'b1;
      step("pre_rst");
      rst = 1'b1;
      step("midrst");
      rst = 1'b0;
      frame();
      scan("after_rst", 10, 14, 20, 1'b1);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(99) < 5) begin
            we = 1'b1; widx = IW'($urandom_range(3));
            wx = 11'($urandom_range(50)); ww = 11'($urandom_range(20));
            wy = 10'($urandom_range(15, 35)); wh = 10'($urandom_range(8));
            wr = 4'($urandom); wg = 4'($urandom); wb = 4'($urandom);
            wen = ($urandom_range(9) != 0); wbl = $urandom_range(1);
         end else begin
            we = 1'b0;
         end
         fs  = ($urandom_range(99) < 3);
         rst = ($urandom_range(999) < 3);
         px  = 11'($urandom_range(70));
         py  = 10'($urandom_range(12, 45));
         ins = ($urandom_range(9) != 0);
         step("random");
      end
      we = 1'b0; fs = 1'b0; rst = 1'b0; ins = 1'b0;
      step("drain");
      step("drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
